// File: rtl/muon_coinc_tdc.sv
// muon_coinc_tdc: multi-channel start coincidence, stop-channel TDC and a
// one-entry valid/ready measurement slot with saturating statistics.
//
// A start is a rising edge on every channel of start_mask, all seen within a
// WIN-cycle window counted from the first masked edge. The cycle the set
// completes is t0. The first rising edge on stop_sel after t0 posts the
// elapsed cycle count. If no stop edge arrives, a timeout record of TIMEOUT
// is posted once TIMEOUT cycles have elapsed.
//
// Optional build macro: MUON_DEADTIME_EN
//   When defined, each post is followed by DEAD cycles in which every edge is
//   ignored. When undefined, the FSM re-arms on the cycle after a post.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ch_in[NCH]        synchronised detector levels
//   start_mask[NCH]   channels that must all rise for a start
//   stop_sel          index of the stop channel
//   enable            arm acquisition; deassert aborts a running measurement
//   meas_data         elapsed cycles t0->stop, or TIMEOUT
//   meas_timeout      slot holds a timeout record
//   meas_valid        slot occupied
//   meas_ready        consumer accepts the slot
//   coinc_count       completed start coincidences (saturating)
//   timeout_count     timeout records generated (saturating)
//   drop_count        records lost to a full slot (saturating)
//   busy              FSM not idle
module muon_coinc_tdc #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned WIN     = 4,
  parameter int unsigned TIMEOUT = 600,
  parameter int unsigned TDC_W   = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEAD    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         ch_in,
  input  logic [NCH-1:0]         start_mask,
  input  logic [$clog2(NCH)-1:0] stop_sel,
  input  logic                   enable,
  output logic [TDC_W-1:0]       meas_data,
  output logic                   meas_timeout,
  output logic                   meas_valid,
  input  logic                   meas_ready,
  output logic [CNT_W-1:0]       coinc_count,
  output logic [CNT_W-1:0]       timeout_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   busy
);

  // One counter serves the window, the elapsed time and the dead time, so it
  // is sized for the largest of the three.
  localparam int unsigned WIN_W  = $clog2(WIN + 1);
  localparam int unsigned DEAD_W = $clog2(DEAD + 1);
  localparam int unsigned TK_A   = (TDC_W > WIN_W) ? TDC_W : WIN_W;
  localparam int unsigned TK_W   = (TK_A > DEAD_W) ? TK_A : DEAD_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATHER,
    S_TIMING,
    S_DEAD
  } state_t;

  state_t           state, state_n;
  logic [NCH-1:0]   ch_prev;
  logic [NCH-1:0]   seen, seen_n;
  logic [TK_W-1:0]  cnt, cnt_n;

  logic [NCH-1:0]   rise_c;
  logic [NCH-1:0]   hit_c;
  logic [NCH-1:0]   seen_or_c;
  logic             coinc_inc_c;
  logic             post_c;
  logic             post_to_c;
  logic [TDC_W-1:0] post_data_c;

  // Edge detection runs in every state.
  assign rise_c = ch_in & ~ch_prev;
  assign hit_c  = rise_c & start_mask;

  // State, window/elapsed counter and coincidence accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ch_prev <= '0;
      seen    <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ch_prev <= ch_in;
      seen    <= seen_n;
      cnt     <= cnt_n;
      busy    <= (state_n != S_IDLE);
    end
  end

  // Next-state logic and post generation.
  always_comb begin
    state_n     = state;
    seen_n      = seen;
    cnt_n       = cnt;
    seen_or_c   = seen | hit_c;
    coinc_inc_c = 1'b0;
    post_c      = 1'b0;
    post_to_c   = 1'b0;
    post_data_c = '0;

    case (state)
      S_IDLE: begin
        if (enable && (start_mask != '0) && (hit_c != '0)) begin
          seen_n = hit_c;
          if (hit_c == start_mask) begin
            state_n     = S_TIMING;
            cnt_n       = TK_W'(1);
            coinc_inc_c = 1'b1;
          end else begin
            state_n = S_GATHER;
            cnt_n   = TK_W'(1);
          end
        end
      end

      S_GATHER: begin
        seen_n = seen_or_c;
        if (!enable) begin
          state_n = S_IDLE;
        end else if ((start_mask != '0) && (seen_or_c == start_mask)) begin
          state_n     = S_TIMING;
          cnt_n       = TK_W'(1);
          coinc_inc_c = 1'b1;
        end else if (cnt >= TK_W'(WIN)) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + TK_W'(1);
        end
      end

      // cnt holds the elapsed cycles since t0 for the current cycle; the t0
      // cycle itself never reaches this state, so a stop edge there is ignored.
      S_TIMING: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (cnt >= TK_W'(TIMEOUT)) begin
          post_c      = 1'b1;
          post_to_c   = 1'b1;
          post_data_c = TDC_W'(TIMEOUT);
        end else if (rise_c[stop_sel]) begin
          post_c      = 1'b1;
          post_data_c = TDC_W'(cnt);
        end else begin
          cnt_n = cnt + TK_W'(1);
        end
      end

      S_DEAD: begin
        if (!enable || (cnt >= TK_W'(DEAD))) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + TK_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Where the FSM goes after a measurement has been posted.
    if (post_c) begin
`ifdef MUON_DEADTIME_EN
      state_n = (DEAD == 0) ? S_IDLE : S_DEAD;
      cnt_n   = TK_W'(1);
`else
      state_n = S_IDLE;
`endif
    end
  end

  // One-entry output slot; a post that meets a simultaneous accept replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_data    <= '0;
      meas_timeout <= 1'b0;
      meas_valid   <= 1'b0;
      drop_count   <= '0;
    end else if (post_c) begin
      if (!meas_valid || meas_ready) begin
        meas_data    <= post_data_c;
        meas_timeout <= post_to_c;
        meas_valid   <= 1'b1;
      end else if (drop_count != '1) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end else if (meas_valid && meas_ready) begin
      meas_valid <= 1'b0;
    end
  end

  // Saturating coincidence and timeout statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coinc_count   <= '0;
      timeout_count <= '0;
    end else begin
      if (coinc_inc_c && (coinc_count != '1)) begin
        coinc_count <= coinc_count + CNT_W'(1);
      end
      if (post_c && post_to_c && (timeout_count != '1)) begin
        timeout_count <= timeout_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_muon_coinc_tdc.sv
// Scoreboard bench for muon_coinc_tdc: stimulus pushes expected records,
// a negedge monitor pops and compares each accepted slot.
module tb_muon_coinc_tdc;

  localparam int unsigned NCH     = 4;
  localparam int unsigned WIN     = 4;
  localparam int unsigned TIMEOUT = 600;
  localparam int unsigned TDC_W   = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DEAD    = 16;
`ifdef MUON_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   ch_in;
  logic [NCH-1:0]   start_mask;
  logic [1:0]       stop_sel;
  logic             enable;
  logic [TDC_W-1:0] meas_data;
  logic             meas_timeout;
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] coinc_count;
  logic [CNT_W-1:0] timeout_count;
  logic [CNT_W-1:0] drop_count;
  logic             busy;

  muon_coinc_tdc #(
    .NCH(NCH), .WIN(WIN), .TIMEOUT(TIMEOUT), .TDC_W(TDC_W), .CNT_W(CNT_W), .DEAD(DEAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_in(ch_in), .start_mask(start_mask),
    .stop_sel(stop_sel), .enable(enable), .meas_data(meas_data),
    .meas_timeout(meas_timeout), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .coinc_count(coinc_count), .timeout_count(timeout_count),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit to;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_coinc = 0;
  int   exp_timeout = 0;
  int   exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every slot the consumer accepts must match the oldest expectation.
  rec_t mon_r;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && meas_valid === 1'b1 && meas_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got data=%0d timeout=%0b, expected no record",
                 meas_data, meas_timeout);
      end else begin
        mon_r = exp_q.pop_front();
        check("meas_data", 32'(meas_data), mon_r.data);
        check("meas_timeout", 32'(meas_timeout), int'(mon_r.to));
      end
    end
  end

  // One clock; inputs change 1 time unit after the edge. ch3 is unmasked noise.
  task automatic tick();
    @(posedge clk);
    #1;
    ch_in[3] = 1'($urandom_range(0, 1));
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_coinc"}, 32'(coinc_count), exp_coinc);
    check({tag, "_timeout"}, 32'(timeout_count), exp_timeout);
    check({tag, "_drop"}, 32'(drop_count), exp_drop);
  endtask

  // Expected outcome of one start attempt, from the rules alone.
  task automatic expect_meas(input int gap, input int d, input bit dropped);
    rec_t r;
    if (gap <= int'(WIN)) begin
      exp_coinc++;
      if (d < int'(TIMEOUT)) begin
        r.data = d;
        r.to   = 1'b0;
      end else begin
        r.data = int'(TIMEOUT);
        r.to   = 1'b1;
        exp_timeout++;
      end
      if (dropped) exp_drop++;
      else exp_q.push_back(r);
    end
  endtask

  // ch0 rises, ch1 rises gap cycles later (t0), stop ch2 rises d cycles after t0.
  task automatic run_meas(input int gap, input int d, input bit dropped);
    ch_in[2:0] = 3'b000;
    repeat (24) tick();
    ch_in[0] = 1'b1;
    if (gap == 0) ch_in[1] = 1'b1;
    repeat (gap) tick();
    ch_in[1] = 1'b1;
    expect_meas(gap, d, dropped);
    repeat (d) tick();
    ch_in[2] = 1'b1;
    repeat (4) tick();
    check_counters("meas");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int gap;
    int d;
    int drain;

    rst_n      = 1'b0;
    ch_in      = '0;
    start_mask = 4'b0011;
    stop_sel   = 2'd2;
    enable     = 1'b1;
    meas_ready = 1'b1;
    #23;
    check("rst_valid", 32'(meas_valid), 0);
    check("rst_data", 32'(meas_data), 0);
    check("rst_busy", 32'(busy), 0);
    check_counters("rst");
    rst_n = 1'b1;
    repeat (4) tick();

    // Test 1: coincidence, stop at 220, single-cycle valid pulse.
    ch_in[1:0] = 2'b11;
    expect_meas(0, 220, 1'b0);
    repeat (220) tick();
    ch_in[2] = 1'b1;
    check("t1_busy", 32'(busy), 1);
    check("t1_valid_before", 32'(meas_valid), 0);
    tick();
    check("t1_valid_pulse", 32'(meas_valid), 1);
    tick();
    check("t1_valid_after", 32'(meas_valid), 0);
    check_counters("t1");

    // Test 2: window boundaries.
    run_meas(3, 100, 1'b0);
    run_meas(4, 60, 1'b0);
    run_meas(5, 30, 1'b0);

    // Test 3: timeout and the last in-range stop.
    run_meas(1, 599, 1'b0);
    run_meas(0, 600, 1'b0);
    run_meas(2, 640, 1'b0);

    // Stop channel inside the start mask: the t0 edge must not stop.
    ch_in[2:0] = 3'b000;
    start_mask = 4'b0111;
    repeat (24) tick();
    ch_in[2:0] = 3'b111;
    expect_meas(0, 30, 1'b0);
    tick();
    ch_in[2] = 1'b0;
    repeat (29) tick();
    ch_in[2] = 1'b1;
    repeat (4) tick();
    check_counters("mask_stop");
    start_mask = 4'b0011;

    // Test 4: backpressure; second record is dropped.
    meas_ready = 1'b0;
    run_meas(0, 50, 1'b0);
    run_meas(0, 80, 1'b1);
    check("bp_valid_held", 32'(meas_valid), 1);
    check("bp_data_held", 32'(meas_data), 50);
    meas_ready = 1'b1;
    repeat (2) tick();
    check("bp_valid_clear", 32'(meas_valid), 0);
    check("bp_queue_empty", 32'(exp_q.size()), 0);

    // Test 5a: enable drop mid-measurement discards it.
    ch_in[2:0] = 3'b000;
    repeat (24) tick();
    ch_in[1:0] = 2'b11;
    exp_coinc++;
    repeat (300) tick();
    check("abort_busy_before", 32'(busy), 1);
    enable = 1'b0;
    tick();
    check("abort_busy_after", 32'(busy), 0);
    enable = 1'b1;
    ch_in[2] = 1'b1;
    repeat (20) tick();
    check_counters("abort");

    // Test 5b: asynchronous reset mid-measurement, then a fresh measurement.
    ch_in[2:0] = 3'b000;
    repeat (24) tick();
    ch_in[1:0] = 2'b11;
    repeat (100) tick();
    rst_n = 1'b0;
    ch_in = '0;
    #1;
    check("areset_busy", 32'(busy), 0);
    check("areset_valid", 32'(meas_valid), 0);
    check("areset_data", 32'(meas_data), 0);
    check("areset_coinc", 32'(coinc_count), 0);
    exp_coinc = 0;
    exp_timeout = 0;
    exp_drop = 0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    run_meas(0, 40, 1'b0);

    // Test 6: start 10 cycles after a post (rejected only with dead time).
    ch_in[2:0] = 3'b000;
    repeat (24) tick();
    ch_in[1:0] = 2'b11;
    expect_meas(0, 20, 1'b0);
    repeat (20) tick();
    ch_in[2:0] = 3'b100;
    repeat (10) tick();
    ch_in[2:0] = 3'b011;
    if (!DT_EN) expect_meas(0, 20, 1'b0);
    repeat (20) tick();
    ch_in[2] = 1'b1;
    repeat (4) tick();
    check_counters("dead10");

    // Start 17 cycles after a post: always accepted.
    ch_in[2:0] = 3'b000;
    repeat (24) tick();
    ch_in[1:0] = 2'b11;
    expect_meas(0, 15, 1'b0);
    repeat (15) tick();
    ch_in[2:0] = 3'b100;
    repeat (17) tick();
    ch_in[2:0] = 3'b011;
    expect_meas(0, 25, 1'b0);
    repeat (25) tick();
    ch_in[2] = 1'b1;
    repeat (4) tick();
    check_counters("dead17");

    // Randomized attempts across window and timeout boundaries.
    for (int i = 0; i < 30; i++) begin
      gap = int'($urandom_range(0, 6));
      case ($urandom_range(0, 5))
        0:       d = 599;
        1:       d = 600;
        2:       d = 1;
        default: d = int'($urandom_range(1, 650));
      endcase
      run_meas(gap, d, 1'b0);
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 200) begin
      tick();
      drain++;
    end
    check("final_queue_empty", 32'(exp_q.size()), 0);
    check_counters("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
